// File: rtl/vga_layer_arbiter_if.sv
// vga_layer_arbiter_if: layer inputs, priority config and RGB/collision outputs.
// master drives layers and config, slave is the arbiter.
interface vga_layer_arbiter_if #(
  parameter int NUM_LAYERS = 8,
  parameter int COLOR_W    = 24
);
  logic                          active;
  logic                          frame_start;
  logic [NUM_LAYERS-1:0]         layer_valid;
  logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
  logic                          cfg_wr;
  logic [2:0]                    cfg_slot;
  logic [2:0]                    cfg_layer;
  logic                          cfg_en_wr;
  logic [NUM_LAYERS-1:0]         cfg_en;
  logic                          flash;
  logic [COLOR_W-1:0]            pix_out;
  logic [1:0]                    coll;
  logic                          cfg_live;

  modport master (
    output active, frame_start, layer_valid, layer_color,
    output cfg_wr, cfg_slot, cfg_layer, cfg_en_wr, cfg_en, flash,
    input  pix_out, coll, cfg_live
  );

  modport slave (
    input  active, frame_start, layer_valid, layer_color,
    input  cfg_wr, cfg_slot, cfg_layer, cfg_en_wr, cfg_en, flash,
    output pix_out, coll, cfg_live
  );
endinterface

// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter: frame-shadowed priority/enable table, 2-stage pixel mux, overlap monitors.
// Define LAYER_ARB_FLASH_EN to build the full-screen flash override.
module vga_layer_arbiter #(
  parameter int                 NUM_LAYERS    = 8,
  parameter int                 COLOR_W       = 24,
  parameter logic [COLOR_W-1:0] DEFAULT_COLOR = 24'h00FFFF,
  parameter int                 HOLD_CYCLES   = 416800,
  parameter int                 COLL0_A       = 8,
  parameter int                 COLL0_B       = 7,
  parameter int                 COLL1_A       = 8,
  parameter int                 COLL1_B       = 5
) (
  input logic               clk,
  input logic               rst,
  vga_layer_arbiter_if.slave bus
);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  // A monitor index outside the layer range selects nothing, leaving that monitor idle.
  function automatic logic [NUM_LAYERS-1:0] sel_mask(input int idx);
    sel_mask = '0;
    if (idx >= 0 && idx < NUM_LAYERS) sel_mask[idx] = 1'b1;
  endfunction

  localparam logic [NUM_LAYERS-1:0] M0A = sel_mask(COLL0_A);
  localparam logic [NUM_LAYERS-1:0] M0B = sel_mask(COLL0_B);
  localparam logic [NUM_LAYERS-1:0] M1A = sel_mask(COLL1_A);
  localparam logic [NUM_LAYERS-1:0] M1B = sel_mask(COLL1_B);
  localparam logic [19:0]           HOLD = 20'(HOLD_CYCLES);

  state_t                state;
  logic                  live_q;
  logic [2:0]            pend_prio [NUM_LAYERS];
  logic [2:0]            live_prio [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] pend_en;
  logic [NUM_LAYERS-1:0] live_en;
  logic                  cfg_ok;

  logic                  s1_active;
  logic [NUM_LAYERS-1:0] s1_valid;
  logic [NUM_LAYERS-1:0] s1_raw;
  logic [COLOR_W-1:0]    s1_col [NUM_LAYERS];

  logic                  s2_hit;
  logic [COLOR_W-1:0]    pix_d;
  logic [COLOR_W-1:0]    pix_q;
  logic [1:0]            det;
  logic [19:0]           cnt [2];

  assign cfg_ok = bus.cfg_wr
               && ({1'b0, bus.cfg_slot}  < 4'(NUM_LAYERS))
               && ({1'b0, bus.cfg_layer} < 4'(NUM_LAYERS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT_FRAME;
      live_q  <= 1'b0;
      pend_en <= '1;
      live_en <= '1;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pend_prio[i] <= 3'(i);
        live_prio[i] <= 3'(i);
      end
    end else begin
      // Live copy takes the pending value from before any same-cycle write.
      if (bus.frame_start) begin
        live_prio <= pend_prio;
        live_en   <= pend_en;
        state     <= RUN;
        live_q    <= 1'b1;
      end
      for (int i = 0; i < NUM_LAYERS; i++)
        if (cfg_ok && bus.cfg_slot == 3'(i))
          pend_prio[i] <= bus.cfg_layer;
      if (bus.cfg_en_wr) pend_en <= bus.cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_active <= 1'b0;
      s1_valid  <= '0;
      s1_raw    <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) s1_col[i] <= '0;
    end else begin
      s1_active <= bus.active;
      s1_valid  <= bus.layer_valid & live_en;
      s1_raw    <= bus.layer_valid & {NUM_LAYERS{bus.active}};
      for (int i = 0; i < NUM_LAYERS; i++)
        s1_col[i] <= bus.layer_color[i*COLOR_W +: COLOR_W];
    end
  end

`ifdef LAYER_ARB_FLASH_EN
  logic s1_flash;

  always_ff @(posedge clk) begin
    if (rst) s1_flash <= 1'b0;
    else     s1_flash <= bus.flash;
  end
`endif

  always_comb begin
    s2_hit = 1'b0;
    pix_d  = DEFAULT_COLOR;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!s2_hit && s1_valid[live_prio[i]]) begin
        s2_hit = 1'b1;
        pix_d  = s1_col[live_prio[i]];
      end
    end
`ifdef LAYER_ARB_FLASH_EN
    if (s1_flash && !s1_valid[live_prio[0]]) pix_d = '1;
`endif
    if (state != RUN || !s1_active) pix_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pix_q <= '0;
    else     pix_q <= pix_d;
  end

  // Monitors look at raw valids so disabled layers still collide.
  assign det[0] = |(s1_raw & M0A) & |(s1_raw & M0B);
  assign det[1] = |(s1_raw & M1A) & |(s1_raw & M1B);

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst)
        cnt[k] <= '0;
      else if (cnt[k] != '0)
        cnt[k] <= cnt[k] - 20'd1;
      else if (det[k] && state == RUN)
        cnt[k] <= HOLD;
    end
  end

  assign bus.pix_out  = pix_q;
  assign bus.cfg_live = live_q;
  assign bus.coll     = {cnt[1] != '0, cnt[0] != '0};

endmodule

// File: tb/tb_vga_layer_arbiter.sv
// tb_vga_layer_arbiter: directed literals plus random traffic against a frame-level model.
// Build with LAYER_ARB_FLASH_EN to cover the flash override.
`timescale 1ns/1ps
module tb_vga_layer_arbiter;
  localparam int N    = 8;
  localparam int CW   = 24;
  localparam int HOLD = 10;
  localparam int CA0  = 6;
  localparam int CB0  = 7;
  localparam int CA1  = 6;
  localparam int CB1  = 5;
  localparam int MAXC = 4096;
  localparam logic [23:0] DEF = 24'h00FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_layer_arbiter_if #(.NUM_LAYERS(N), .COLOR_W(CW)) bus ();

  vga_layer_arbiter #(
    .NUM_LAYERS(N), .COLOR_W(CW), .DEFAULT_COLOR(DEF),
    .HOLD_CYCLES(HOLD),
    .COLL0_A(CA0), .COLL0_B(CB0), .COLL1_A(CA1), .COLL1_B(CB1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // model state
  bit          m_run;
  int          m_pend [N];
  int          m_live [N];
  logic [N-1:0] m_pen, m_len;
  logic [23:0] exp_pix [MAXC];
  bit          pv [MAXC];
  bit          ck [MAXC];
  bit          el [MAXC];
  bit          ec [2][MAXC];

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [23:0] color(input int i);
    return bus.layer_color[i*CW +: CW];
  endfunction

  // Expectations for inputs of cycle t: pixel at t+2, live flag at t+1, hold windows.
  task automatic model_cycle();
    int t;
    int win;
    int la [2];
    int lb [2];
    logic [N-1:0] vis;
    logic [23:0] p;
    t = cyc;
    if (t + HOLD + 3 >= MAXC) begin
      $display("FAIL model_range cyc=%0d got=%0d want<%0d", t, t + HOLD + 3, MAXC);
      $fatal(1);
    end
    ck[t+1] = 1'b1;
    if (rst) begin
      m_run = 1'b0;
      m_pen = '1;
      m_len = '1;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = i;
        m_live[i] = i;
      end
      exp_pix[t+1] = '0; pv[t+1] = 1'b1;
      exp_pix[t+2] = '0; pv[t+2] = 1'b1;
      el[t+1] = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int x = t + 1; x <= t + HOLD + 2; x++) ec[k][x] = 1'b0;
    end else begin
      vis = bus.layer_valid & m_len;
      if (bus.frame_start) begin
        m_live = m_pend;
        m_len  = m_pen;
        m_run  = 1'b1;
      end
      if (bus.cfg_wr && bus.cfg_slot < N && bus.cfg_layer < N)
        m_pend[bus.cfg_slot] = int'(bus.cfg_layer);
      if (bus.cfg_en_wr) m_pen = bus.cfg_en;
      el[t+1] = m_run;
      win = -1;
      for (int i = 0; i < N; i++)
        if (win < 0 && vis[m_live[i]]) win = m_live[i];
      p = (win >= 0) ? color(win) : DEF;
`ifdef LAYER_ARB_FLASH_EN
      if (bus.flash && !vis[m_live[0]]) p = 24'hFFFFFF;
`endif
      if (!m_run || !bus.active) p = '0;
      exp_pix[t+2] = p;
      pv[t+2] = 1'b1;
      la[0] = CA0; la[1] = CA1;
      lb[0] = CB0; lb[1] = CB1;
      for (int k = 0; k < 2; k++)
        if (m_run && bus.active && bus.layer_valid[la[k]] &&
            bus.layer_valid[lb[k]] && !ec[k][t+1])
          for (int x = t + 2; x <= t + 1 + HOLD; x++) ec[k][x] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (pv[cyc]) check("pix_out", bus.pix_out, exp_pix[cyc]);
      if (ck[cyc]) begin
        check("coll", {22'b0, bus.coll}, {22'b0, ec[1][cyc], ec[0][cyc]});
        check("cfg_live", {23'b0, bus.cfg_live}, {23'b0, el[cyc]});
      end
    end
  end

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.active      = 1'b0;
    bus.frame_start = 1'b0;
    bus.layer_valid = '0;
    bus.cfg_wr      = 1'b0;
    bus.cfg_slot    = '0;
    bus.cfg_layer   = '0;
    bus.cfg_en_wr   = 1'b0;
    bus.cfg_en      = '0;
    bus.flash       = 1'b0;
    for (int i = 0; i < N; i++)
      bus.layer_color[i*CW +: CW] = 24'(24'hA0A0A0 + 24'h010101 * i);
  endtask

  task automatic frame();
    bus.active      = 1'b0;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  int t0;
  logic exp_c;

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    check("rst_pix", bus.pix_out, 24'h0);
    check("rst_coll", {22'b0, bus.coll}, 24'h0);
    check("rst_live", {23'b0, bus.cfg_live}, 24'h0);

    rst = 1'b0;
    bus.active = 1'b1;
    bus.layer_valid = 8'hFF;
    repeat (4) step();
    check("wait_pix", bus.pix_out, 24'h0);
    check("wait_live", {23'b0, bus.cfg_live}, 24'h0);
    check("wait_coll", {22'b0, bus.coll}, 24'h0);

    frame();
    check("live_up", {23'b0, bus.cfg_live}, 24'h1);
    bus.active = 1'b1;
    bus.layer_valid = 8'h28;
    step();
    check("lat_t1", bus.pix_out, 24'h0);
    step();
    check("lat_t2", bus.pix_out, 24'hA3A3A3);

    bus.cfg_wr = 1'b1; bus.cfg_slot = 3'd0; bus.cfg_layer = 3'd5;
    bus.cfg_en_wr = 1'b1; bus.cfg_en = 8'hF7;
    step();
    bus.cfg_wr = 1'b0; bus.cfg_en_wr = 1'b0;
    step();
    step();
    check("shadow_hold", bus.pix_out, 24'hA3A3A3);
    frame();
    bus.active = 1'b1;
    step();
    step();
    check("new_slot0", bus.pix_out, 24'hA5A5A5);
    bus.layer_valid = 8'h08;
    step();
    step();
    check("default_col", bus.pix_out, DEF);
    bus.flash = 1'b1;
    step();
    step();
`ifdef LAYER_ARB_FLASH_EN
    check("flash_on", bus.pix_out, 24'hFFFFFF);
`else
    check("flash_off", bus.pix_out, DEF);
`endif
    bus.layer_valid = 8'h20;
    step();
    step();
    check("flash_slot0", bus.pix_out, 24'hA5A5A5);
    bus.flash = 1'b0;

    bus.cfg_wr = 1'b1; bus.cfg_slot = 3'd1; bus.cfg_layer = 3'd2;
    frame();
    bus.cfg_wr = 1'b0;
    bus.active = 1'b1;
    bus.layer_valid = 8'h06;
    step();
    step();
    check("same_cyc_wr", bus.pix_out, 24'hA1A1A1);
    frame();
    bus.active = 1'b1;
    step();
    step();
    check("next_frame_wr", bus.pix_out, 24'hA2A2A2);

    bus.cfg_en_wr = 1'b1; bus.cfg_en = 8'h7F;
    bus.active = 1'b0;
    bus.layer_valid = 8'h00;
    step();
    bus.cfg_en_wr = 1'b0;
    frame();
    bus.active = 1'b1;
    step();
    t0 = cyc;
    bus.layer_valid = 8'hC0;
    step();
    for (int c = t0 + 1; c <= t0 + 26; c++) begin
      exp_c = (c >= t0 + 2 && c <= t0 + 11) || (c >= t0 + 14 && c <= t0 + 23);
      check("coll0_hold", {23'b0, bus.coll[0]}, {23'b0, exp_c});
      if (c == t0 + 2) check("hidden_pix", bus.pix_out, 24'hA6A6A6);
      bus.layer_valid = (c == t0 + 5 || c == t0 + 12) ? 8'hC0 : 8'h00;
      step();
    end
    bus.active = 1'b0;
    bus.layer_valid = 8'hC0;
    step();
    bus.active = 1'b1;
    bus.layer_valid = 8'h00;
    step();
    check("inact_pix", bus.pix_out, 24'h0);
    check("inact_coll", {22'b0, bus.coll}, 24'h0);
    step();
    check("inact_coll2", {22'b0, bus.coll}, 24'h0);

    bus.layer_valid = 8'hFF;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("midrst_pix", bus.pix_out, 24'h0);
    check("midrst_live", {23'b0, bus.cfg_live}, 24'h0);

    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 599) == 0);
      bus.frame_start = ($urandom_range(0, 39) == 0);
      bus.active = bus.frame_start ? 1'b0 : ($urandom_range(0, 4) != 0);
      bus.layer_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        bus.layer_color[i*CW +: CW] = 24'($urandom);
      bus.cfg_wr    = ($urandom_range(0, 24) == 0);
      bus.cfg_slot  = 3'($urandom);
      bus.cfg_layer = 3'($urandom);
      bus.cfg_en_wr = ($urandom_range(0, 59) == 0);
      bus.cfg_en    = N'($urandom | $urandom);
      bus.flash     = 1'($urandom);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
